// File: rtl/oled_spi_rx_pkg.sv
// Shared types and constants for the OLED SPI responder.
// Bus bit positions refer to the synchronised {cs, sclk, sdo, dc} vector.
package oled_spi_rx_pkg;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  localparam logic [5:0] OLED_CMD_PAGE_MASK = 6'b101100;

  localparam int BUS_W  = 4;
  localparam int B_CS   = 3;
  localparam int B_SCLK = 2;
  localparam int B_SDO  = 1;
  localparam int B_DC   = 0;

  // cs and sclk idle high
  localparam logic [BUS_W-1:0] BUS_IDLE = 4'b1100;

  function automatic logic is_page_cmd(input logic [7:0] b);
    return b[7:2] == OLED_CMD_PAGE_MASK;
  endfunction

endpackage

// File: rtl/oled_spi_rx_if.sv
// OLED link: SPI lines from the controller plus decoded byte and
// frame-buffer write outputs of the responder.
interface oled_spi_rx_if #(
  parameter int ADDR_W = 9
);
  logic              cs;
  logic              sclk;
  logic              sdo;
  logic              dc;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_dc;
  logic              cmd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output cs, sclk, sdo, dc,
    input  byte_valid, byte_data, byte_dc,
    input  cmd_valid, wr_en, wr_addr, wr_data,
    input  frame_done, frame_err
  );

  modport slave (
    input  cs, sclk, sdo, dc,
    output byte_valid, byte_data, byte_dc,
    output cmd_valid, wr_en, wr_addr, wr_data,
    output frame_done, frame_err
  );
endinterface

// File: rtl/oled_spi_rx_sync.sv
// N-flop synchroniser for a small bus plus rising-edge detect on
// one selected bit; every bit sees the same delay.
module oled_spi_rx_sync #(
  parameter int             N        = 2,
  parameter int             W        = 4,
  parameter logic [W-1:0]   RST_VAL  = '0,
  parameter int             RISE_BIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o
);

  logic [W-1:0] ff_q [N];
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ff_q[i] <= RST_VAL;
      prev_q <= RST_VAL[RISE_BIT];
    end else begin
      ff_q[0] <= d_i;
      for (int i = 1; i < N; i++) ff_q[i] <= ff_q[i-1];
      prev_q <= ff_q[N-1][RISE_BIT];
    end
  end

  assign q_o    = ff_q[N-1];
  assign rise_o = ff_q[N-1][RISE_BIT] & ~prev_q;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED SPI responder: deserialises cs/sclk/sdo/dc into bytes and
// turns data bytes into page-ordered frame-buffer writes.
module oled_spi_rx
  import oled_spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FB_BYTES    = 512,
  parameter int ADDR_W      = 9
) (
  input  logic           clk,
  input  logic           rst,
  oled_spi_rx_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  logic [BUS_W-1:0] sync_s;
  logic             sclk_rise;

  oled_spi_rx_sync #(
    .N        (SYNC_STAGES),
    .W        (BUS_W),
    .RST_VAL  (BUS_IDLE),
    .RISE_BIT (B_SCLK)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({bus.cs, bus.sclk, bus.sdo, bus.dc}),
    .q_o    (sync_s),
    .rise_o (sclk_rise)
  );

  logic cs_s, sdo_s, dc_s;
  assign cs_s  = sync_s[B_CS];
  assign sdo_s = sync_s[B_SDO];
  assign dc_s  = sync_s[B_DC];

  rx_state_e         state_q;
  logic [2:0]        cnt_q;
  logic [7:0]        sh_q;
  logic              bv_q, bdc_q, cmd_q, wen_q;
  logic              fd_q, fe_q;
  logic [7:0]        bdata_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;

  logic [7:0] byte_d;
  logic       accept_d;

  assign byte_d = {sh_q[6:0], sdo_s};
  // 8th edge wins over a simultaneous cs release
  assign accept_d = (state_q == RX_SHIFT) && sclk_rise
                    && (cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      bdc_q   <= 1'b0;
      cmd_q   <= 1'b0;
      wen_q   <= 1'b0;
      fd_q    <= 1'b0;
      fe_q    <= 1'b0;
      bdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      bv_q  <= 1'b0;
      cmd_q <= 1'b0;
      wen_q <= 1'b0;
      fd_q  <= 1'b0;
      fe_q  <= 1'b0;

      if (accept_d) begin
        bv_q    <= 1'b1;
        bdata_q <= byte_d;
        bdc_q   <= dc_s;
        cmd_q   <= ~dc_s;
        wen_q   <= dc_s;
        if (dc_s) begin
          wdata_q <= byte_d;
          fd_q    <= (addr_q == LAST_ADDR);
        end
      end

      if (bv_q) begin
        if (bdc_q)
          addr_q <= addr_q + 1'b1;
        else if (is_page_cmd(bdata_q))
          addr_q <= ADDR_W'({bdata_q[1:0], 7'd0});
      end

      unique case (state_q)
        RX_IDLE: begin
          if (!cs_s) begin
            state_q <= RX_SHIFT;
            cnt_q   <= '0;
            sh_q    <= '0;
          end
        end
        RX_SHIFT: begin
          if (cs_s) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            fe_q    <= (cnt_q != 3'd0) && !accept_d;
          end else if (sclk_rise) begin
            sh_q  <= byte_d;
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.byte_valid = bv_q;
  assign bus.byte_data  = bdata_q;
  assign bus.byte_dc    = bdc_q;
  assign bus.cmd_valid  = cmd_q;
  assign bus.wr_en      = wen_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = wdata_q;
  assign bus.frame_done = fd_q;
  assign bus.frame_err  = fe_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: drives SPI bytes and checks the
// decoded byte stream and frame-buffer writes.
module tb_oled_spi_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  oled_spi_rx_if #(.ADDR_W(9)) bus ();

  oled_spi_rx #(
    .SYNC_STAGES (2),
    .FB_BYTES    (512),
    .ADDR_W      (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // monitor
  int         nbv = 0, ncmd = 0, nfe = 0, nfd = 0;
  logic [7:0] last_byte = '0;
  logic       last_dc = 1'b0, last_cmd = 1'b0, last_wen = 1'b0;
  logic [8:0] fd_addr = '0;
  logic       fd_wen = 1'b0;
  logic [8:0] wa[$];
  logic [7:0] wd[$];

  always @(negedge clk) begin
    if (bus.byte_valid) begin
      nbv++;
      last_byte = bus.byte_data;
      last_dc   = bus.byte_dc;
      last_cmd  = bus.cmd_valid;
      last_wen  = bus.wr_en;
    end
    if (bus.cmd_valid) ncmd++;
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
    end
    if (bus.frame_err) nfe++;
    if (bus.frame_done) begin
      nfd++;
      fd_addr = bus.wr_addr;
      fd_wen  = bus.wr_en;
    end
  end

  task automatic spi_bit(input logic b, input int half,
                         input bit cs_on_rise);
    bus.sclk = 1'b0;
    bus.sdo  = b;
    repeat (half) @(negedge clk);
    bus.sclk = 1'b1;
    if (cs_on_rise) bus.cs = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d,
                           input int half, input bit cs_end);
    bus.dc = d;
    for (int i = 7; i >= 0; i--)
      spi_bit(b[i], half, cs_end && (i == 0));
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test1(input int half);
    int b0, w0;
    b0 = nbv; w0 = wa.size();
    cs_low();
    send_byte(8'hAE, 1'b0, half, 1'b0);
    cs_high();
    check("t1_nbv", nbv - b0, 1);
    check("t1_byte", last_byte, 8'hAE);
    check("t1_dc", last_dc, 0);
    check("t1_cmd", last_cmd, 1);
    check("t1_wen", last_wen, 0);
    check("t1_nwr", wa.size() - w0, 0);
    check("t1_addr", bus.wr_addr, 0);
  endtask

  task automatic test2(input int half);
    int w0;
    w0 = wa.size();
    cs_low();
    send_byte(8'hB2, 1'b0, half, 1'b0);
    send_byte(8'h55, 1'b1, half, 1'b0);
    send_byte(8'hAA, 1'b1, half, 1'b0);
    cs_high();
    check("t2_nwr", wa.size() - w0, 2);
    if (wa.size() >= w0 + 2) begin
      check("t2_a0", wa[w0], 9'h100);
      check("t2_d0", wd[w0], 8'h55);
      check("t2_a1", wa[w0+1], 9'h101);
      check("t2_d1", wd[w0+1], 8'hAA);
    end
    check("t2_addr", bus.wr_addr, 9'h102);
  endtask

  initial begin
    int b0, w0, f0, d0, bad;
    bus.cs   = 1'b1;
    bus.sclk = 1'b1;
    bus.sdo  = 1'b0;
    bus.dc   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bv", bus.byte_valid, 0);
    check("rst_byte", bus.byte_data, 0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_wdata", bus.wr_data, 0);
    check("rst_fe", bus.frame_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    test1(4);
    test2(4);

    // full frame
    w0 = wa.size(); d0 = nfd;
    cs_low();
    send_byte(8'hB0, 1'b0, 4, 1'b0);
    for (int i = 0; i < 512; i++)
      send_byte(8'(i), 1'b1, 4, 1'b0);
    cs_high();
    check("t3_nwr", wa.size() - w0, 512);
    bad = 0;
    if (wa.size() >= w0 + 512)
      for (int i = 0; i < 512; i++)
        if (wa[w0+i] !== 9'(i) || wd[w0+i] !== 8'(i)) bad++;
    check("t3_order", bad, 0);
    check("t3_nfd", nfd - d0, 1);
    check("t3_fd_addr", fd_addr, 9'd511);
    check("t3_fd_wen", fd_wen, 1);
    check("t3_addr", bus.wr_addr, 0);

    // truncated byte
    b0 = nbv; f0 = nfe;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 4, 1'b0);
    cs_high();
    check("t4_nfe", nfe - f0, 1);
    check("t4_nbv", nbv - b0, 0);
    cs_low();
    send_byte(8'h3C, 1'b0, 4, 1'b0);
    cs_high();
    check("t4_nbv2", nbv - b0, 1);
    check("t4_byte", last_byte, 8'h3C);

    // cs release together with 8th edge
    b0 = nbv; f0 = nfe;
    cs_low();
    send_byte(8'h81, 1'b0, 4, 1'b1);
    repeat (8) @(negedge clk);
    check("t5_nbv", nbv - b0, 1);
    check("t5_byte", last_byte, 8'h81);
    check("t5_nfe", nfe - f0, 0);

    // reset mid-byte
    b0 = nbv; f0 = nfe;
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit(i[0], 4, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_byte", bus.byte_data, 0);
    check("t6_dc", bus.byte_dc, 0);
    check("t6_wdata", bus.wr_data, 0);
    check("t6_addr", bus.wr_addr, 0);
    check("t6_bv", bus.byte_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cs_high();
    check("t6_nfe", nfe - f0, 0);
    cs_low();
    send_byte(8'h12, 1'b0, 4, 1'b0);
    cs_high();
    check("t6_nbv", nbv - b0, 1);
    check("t6_byte2", last_byte, 8'h12);
    check("t6_nfe2", nfe - f0, 0);

    // faster sclk
    test1(2);
    test2(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
